// File: rtl/weight_bank_int8.sv
// INT8 weight bank: host loads row-major weights over a 32-bit stream, engine reads one byte per cycle combinationally.
// Optional load checksum is enabled with the WEIGHT_BANK_CHECKSUM_EN macro.
module weight_bank_int8 #(
  parameter int IN_DIM  = 128,
  parameter int OUT_DIM = 128,
  parameter int DEPTH   = IN_DIM * OUT_DIM,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_start_i,
  input  logic          s_valid_i,
  input  logic [31:0]   s_data_i,
  output logic          s_ready_o,
  output logic          load_done_o,
  output logic          loaded_o,
  input  logic [AW-1:0] weight_addr_i,
  output logic [7:0]    weight_data_o,
  output logic [15:0]   checksum_o,
  output logic [1:0]    dbg_state_o
);

  localparam int WORDS = DEPTH / 4;
  localparam logic [AW-3:0] LAST_WORD = (AW-2)'(WORDS - 1);
  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);

  if ((DEPTH % 4) != 0 || DEPTH < 8) begin : g_depth_check
    $error("weight_bank_int8: DEPTH must be a multiple of 4 and at least 8");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AW-3:0]     r_wptr;      // word pointer: byte write pointer divided by 4
  logic              r_done;
  logic [31:0]       r_mem [WORDS];
  logic              w_accept;
  logic              w_last;
  logic [31:0]       w_rd_word;

  // Stream handshake: a beat transfers on a clock edge where s_valid_i and s_ready_o are both high;
  // s_ready_o is low outside LOAD and during any load_start_i cycle, so such beats are simply dropped.
  assign s_ready_o   = (r_state == ST_LOAD) & ~load_start_i;
  assign w_accept    = s_valid_i & s_ready_o;
  assign w_last      = w_accept & (r_wptr == LAST_WORD);
  assign loaded_o    = (r_state == ST_FULL);
  assign load_done_o = r_done;
  assign dbg_state_o = r_state;

  always_comb begin
    w_state_nxt = r_state;
    if (load_start_i) begin
      w_state_nxt = ST_LOAD;
    end else if (w_last) begin
      w_state_nxt = ST_FULL;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_wptr  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_last;
      if (load_start_i || w_last) begin
        r_wptr <= '0;
      end else if (w_accept) begin
        r_wptr <= r_wptr + 1'b1;
      end
    end
  end

  // Storage is deliberately not reset; reads are masked until a full matrix is present.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_mem[r_wptr] <= s_data_i;
    end
  end

  always_comb begin
    w_rd_word     = r_mem[weight_addr_i[AW-1:2]];
    weight_data_o = 8'd0;
    if (loaded_o && ({1'b0, weight_addr_i} < DEPTH_W)) begin
      case (weight_addr_i[1:0])
        2'd0:    weight_data_o = w_rd_word[7:0];
        2'd1:    weight_data_o = w_rd_word[15:8];
        2'd2:    weight_data_o = w_rd_word[23:16];
        default: weight_data_o = w_rd_word[31:24];
      endcase
    end
  end

`ifdef WEIGHT_BANK_CHECKSUM_EN
  logic [15:0] r_checksum;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_checksum <= 16'd0;
    end else if (load_start_i) begin
      r_checksum <= 16'd0;
    end else if (w_accept) begin
      r_checksum <= r_checksum + 16'(s_data_i[7:0]) + 16'(s_data_i[15:8])
                               + 16'(s_data_i[23:16]) + 16'(s_data_i[31:24]);
    end
  end

  assign checksum_o = r_checksum;
`else
  assign checksum_o = 16'd0;
`endif

endmodule

// File: tb/tb_weight_bank_int8.sv
// Self-checking bench for weight_bank_int8: default 128x128, 8x4 and 8x3 instances.
module tb_weight_bank_int8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Default-size instance
  logic        b_start = 0, b_valid = 0;
  logic [31:0] b_data = 0;
  logic        b_ready, b_done, b_loaded;
  logic [13:0] b_addr = 0;
  logic [7:0]  b_rdata;
  logic [15:0] b_csum;
  logic [1:0]  b_dbg;

  // 8x4 instance (DEPTH 32)
  logic        s_start = 0, s_valid = 0;
  logic [31:0] s_data = 0;
  logic        s_ready, s_done, s_loaded;
  logic [4:0]  s_addr = 0;
  logic [7:0]  s_rdata;
  logic [15:0] s_csum;
  logic [1:0]  s_dbg;

  // 8x3 instance (DEPTH 24, AW 5)
  logic        o_start = 0, o_valid = 0;
  logic [31:0] o_data = 0;
  logic        o_ready, o_done, o_loaded;
  logic [4:0]  o_addr = 0;
  logic [7:0]  o_rdata;
  logic [15:0] o_csum;
  logic [1:0]  o_dbg;

  weight_bank_int8 u_big (
    .clk_i(clk), .rst_ni(rst_n), .load_start_i(b_start), .s_valid_i(b_valid),
    .s_data_i(b_data), .s_ready_o(b_ready), .load_done_o(b_done), .loaded_o(b_loaded),
    .weight_addr_i(b_addr), .weight_data_o(b_rdata), .checksum_o(b_csum), .dbg_state_o(b_dbg)
  );

  weight_bank_int8 #(.IN_DIM(8), .OUT_DIM(4)) u_small (
    .clk_i(clk), .rst_ni(rst_n), .load_start_i(s_start), .s_valid_i(s_valid),
    .s_data_i(s_data), .s_ready_o(s_ready), .load_done_o(s_done), .loaded_o(s_loaded),
    .weight_addr_i(s_addr), .weight_data_o(s_rdata), .checksum_o(s_csum), .dbg_state_o(s_dbg)
  );

  weight_bank_int8 #(.IN_DIM(8), .OUT_DIM(3)) u_odd (
    .clk_i(clk), .rst_ni(rst_n), .load_start_i(o_start), .s_valid_i(o_valid),
    .s_data_i(o_data), .s_ready_o(o_ready), .load_done_o(o_done), .loaded_o(o_loaded),
    .weight_addr_i(o_addr), .weight_data_o(o_rdata), .checksum_o(o_csum), .dbg_state_o(o_dbg)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the 8x4 bank: a byte list since the last start, committed when 32 bytes arrive.
  logic        m_loading = 0, m_loaded = 0, m_done = 0;
  logic [7:0]  m_q[$];
  logic [7:0]  m_mem[32];
  logic [15:0] m_sum = 0;
  int          s_hs = 0;
  logic [31:0] exp_q[$];

  function automatic logic [15:0] csum_exp(input logic [15:0] model_sum);
`ifdef WEIGHT_BANK_CHECKSUM_EN
    return model_sum;
`else
    return 16'd0;
`endif
  endfunction

  // Called at posedge+1: drives one cycle, checks at negedge, advances the model, returns at next posedge+1.
  task automatic s_cycle(input logic st, input logic vl, input logic [31:0] d, input logic [4:0] a);
    logic done_n;
    s_start = st; s_valid = vl; s_data = d; s_addr = a;
    @(negedge clk);
    chk("s_ready", s_ready, m_loading & ~st);
    chk("s_loaded", s_loaded, m_loaded);
    chk("s_done", s_done, m_done);
    chk("s_rdata", s_rdata, m_loaded ? 32'(m_mem[a]) : 32'd0);
    chk("s_csum", s_csum, csum_exp(m_sum));
    if (s_valid && s_ready) s_hs++;
    done_n = 1'b0;
    if (st) begin
      m_loading = 1'b1; m_loaded = 1'b0; m_sum = 16'd0;
      m_q.delete();
      exp_q.delete();
    end else if (m_loading && vl) begin
      exp_q.push_back(d);
      for (int i = 0; i < 4; i++) begin
        m_q.push_back(d[8*i +: 8]);
        m_sum = m_sum + 16'(d[8*i +: 8]);
      end
      if (m_q.size() == 32) begin
        for (int i = 0; i < 32; i++) m_mem[i] = m_q[i];
        m_loaded = 1'b1; m_loading = 1'b0; done_n = 1'b1;
      end
    end
    m_done = done_n;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] big_beat(input int k);
    int b;
    b = (4 * k) % 256;
    return {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
  endfunction

  typedef struct {
    logic [13:0] addr;
    logic [7:0]  exp;
  } rd_vec_t;

  initial begin
    rd_vec_t     vecs[8];
    int          nb, cyc, early, hs0;
    logic        hs;
    logic [15:0] big_sum;
    logic [31:0] w;

    vecs[0] = '{14'h1234, 8'h34};
    vecs[1] = '{14'h3FFF, 8'hFF};
    vecs[2] = '{14'h0000, 8'h00};
    vecs[3] = '{14'h0001, 8'h01};
    vecs[4] = '{14'h00FF, 8'hFF};
    vecs[5] = '{14'h2002, 8'h02};
    vecs[6] = '{14'h1001, 8'h01};
    vecs[7] = '{14'h3F80, 8'h80};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", {b_ready, s_ready, o_ready}, 3'b000);
    chk("rst_loaded", {b_loaded, s_loaded, o_loaded}, 3'b000);
    chk("rst_done", {b_done, s_done, o_done}, 3'b000);
    chk("rst_rdata", {b_rdata, s_rdata, o_rdata}, 24'd0);
    chk("rst_csum_big", b_csum, 16'd0);
    chk("rst_csum_small", s_csum, 16'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Pre-load reads
    for (int i = 0; i < 4; i++) begin
      b_addr = 14'($urandom); o_addr = 5'($urandom_range(0, 31));
      @(negedge clk);
      chk("preload_big", b_rdata, 8'd0);
      chk("preload_odd", o_rdata, 8'd0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 4; i++) s_cycle(1'b0, 1'b1, $urandom, 5'($urandom_range(0, 31)));

    // Full default load with byte[a] = a[7:0], valid held high
    b_start = 1; b_valid = 1; b_data = big_beat(0);
    @(negedge clk);
    chk("big_start_no_handshake", b_ready, 1'b0);
    @(posedge clk); #1;
    b_start = 0;
    nb = 0; cyc = 0; early = 0; big_sum = 16'd0;
    while (nb < 4096 && cyc < 5000) begin
      @(negedge clk);
      hs = b_valid & b_ready;
      if (b_done || b_loaded) early++;
      if (hs) begin
        for (int i = 0; i < 4; i++) big_sum = big_sum + 16'(b_data[8*i +: 8]);
      end
      @(posedge clk); #1;
      if (hs) begin
        nb++;
        b_data = big_beat(nb);
      end
      cyc++;
    end
    b_valid = 0;
    chk("big_beats", nb, 4096);
    chk("big_cycles", cyc, 4096);
    chk("big_no_early_done", early, 0);
    @(negedge clk);
    chk("big_done_pulse", b_done, 1'b1);
    chk("big_loaded", b_loaded, 1'b1);
    chk("big_csum_model", b_csum, csum_exp(big_sum));
`ifdef WEIGHT_BANK_CHECKSUM_EN
    chk("big_csum_const", b_csum, 16'hE000);
`endif
    @(posedge clk); #1;
    @(negedge clk);
    chk("big_done_one_cycle", b_done, 1'b0);
    chk("big_full_ready", b_ready, 1'b0);
    chk("big_still_loaded", b_loaded, 1'b1);

    // Table-driven readback
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      b_addr = vecs[i].addr;
      @(negedge clk);
      chk($sformatf("big_read_%0h", vecs[i].addr), b_rdata, vecs[i].exp);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      b_addr = 14'($urandom);
      @(negedge clk);
      chk("big_read_rand", b_rdata, {24'd0, b_addr[7:0]});
    end
    @(posedge clk); #1;

    // Backpressure on 8x4: valid toggles 1,0,1,0
    s_cycle(1'b1, 1'b0, 32'd0, 5'd0);
    s_hs = 0;
    for (int i = 0; i < 16; i++) s_cycle(1'b0, (i % 2) == 0, $urandom, 5'd0);
    chk("bp_writes", s_hs, 8);
    chk("bp_loaded", s_loaded, 1'b1);
    chk("bp_exp_words", exp_q.size(), 8);
    for (int a = 0; a < 32; a++) begin
      s_cycle(1'b0, 1'b0, 32'd0, 5'(a));
      w = exp_q[a / 4];
      chk("bp_readback", s_rdata, {24'd0, w[8*(a%4) +: 8]});
    end

    // Restart after 3 of 8 beats
    s_cycle(1'b1, 1'b1, 32'hDEADBEEF, 5'd0);
    chk("rs_loaded_cleared", s_loaded, 1'b0);
    for (int i = 0; i < 3; i++) s_cycle(1'b0, 1'b1, $urandom, 5'd0);
    hs0 = s_hs;
    s_cycle(1'b1, 1'b1, 32'h11223344, 5'd0);
    chk("rs_no_handshake_on_start", s_hs - hs0, 0);
    for (int i = 0; i < 7; i++) s_cycle(1'b0, 1'b1, 32'h80818283, 5'd0);
    chk("rs_not_loaded_7", s_loaded, 1'b0);
    s_cycle(1'b0, 1'b1, 32'h80818283, 5'd0);
    chk("rs_beats", s_hs - hs0, 8);
    s_cycle(1'b0, 1'b0, 32'd0, 5'd0);
    for (int a = 0; a < 32; a += 4) begin
      s_cycle(1'b0, 1'b0, 32'd0, 5'(a));
      chk("rs_byte0_lane", 32'($signed(s_rdata)), 32'(-125));
    end

    // 8x3: the >= DEPTH rule
    o_start = 1;
    @(posedge clk); #1;
    o_start = 0; o_valid = 1;
    for (int k = 0; k < 6; k++) begin
      o_data = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      @(posedge clk); #1;
    end
    o_valid = 0;
    @(negedge clk);
    chk("odd_done", o_done, 1'b1);
    chk("odd_loaded", o_loaded, 1'b1);
    for (int a = 20; a < 32; a++) begin
      @(posedge clk); #1;
      o_addr = 5'(a);
      @(negedge clk);
      chk($sformatf("odd_read_%0d", a), o_rdata, (a < 24) ? 32'(a) : 32'd0);
    end
    @(posedge clk); #1;

    // Randomized traffic on 8x4 against the model
    for (int i = 0; i < 400; i++) begin
      s_cycle($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)), $urandom,
              5'($urandom_range(0, 31)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
